// File: rtl/shift_tx_seq.sv
// shift_tx_seq: upstream sequencer for a universal shift register.
// Accepts parallel words over a valid/ready handshake. For each word it issues
// one parallel load followed by WIDTH shifts, so the register's s_out presents
// the word serially, MSB-first (mode 01) or LSB-first (mode 10). A one-entry
// buffer holds the next word while the current one shifts, so back-to-back
// words stream with a period of WIDTH+1 cycles (plus GAP_CYCLES hold cycles).
//
// Ports
//   clk, rst   rising-edge clock; synchronous active-high reset
//   in_data    word to serialize          in_lsb   1 = LSB-first, 0 = MSB-first
//   in_valid   in_data/in_lsb valid       in_ready buffer empty (not in reset)
//   fill_bit   value shifted into the vacated end during shifts
//   sr_mode    00 hold, 01 shift-left, 10 shift-right, 11 load
//   sr_p_in    parallel value for the register (held outside LOAD)
//   sr_s_in    serial input for the register (fill_bit in SHIFT, else 0)
//   busy       high in LOAD, SHIFT and GAP
//   bit_cnt    shifts completed for the current word
//   word_done  one-cycle pulse once the word's final bit is on s_out
module shift_tx_seq #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fill_bit,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_p_in,
  output logic             sr_s_in,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         mode_d;
  logic               buf_full;
  logic [WIDTH-1:0]   buf_data;
  logic               buf_lsb;
  logic               cur_lsb;
  logic [7:0]         gap_cnt;
  logic               shift_last;
  logic               gap_last;
  logic               shift_lsb;
  logic               accept;

  assign in_ready   = ~buf_full & ~rst;
  assign accept     = in_valid & in_ready;
  assign shift_last = (state_q == S_SHIFT) && (bit_cnt == CNT_LAST);
  assign gap_last   = (state_q == S_GAP) && (gap_cnt == GAP_LAST);
  // On the LOAD->SHIFT edge cur_lsb is not yet updated, so take the
  // direction straight from the buffer.
  assign shift_lsb  = (state_q == S_LOAD) ? buf_lsb : cur_lsb;

  // Next-state and next-output decode; outputs are registered from state_d
  // so the pins always reflect the state they belong to.
  always_comb begin
    state_d = state_q;
    mode_d  = 2'b00;
    case (state_q)
      S_IDLE:  if (buf_full) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        if (shift_last) begin
          if (GAP_CYCLES > 0)  state_d = S_GAP;
          else if (buf_full)   state_d = S_LOAD;
          else                 state_d = S_IDLE;
        end
      end
      S_GAP:   if (gap_last) state_d = buf_full ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_LOAD:  mode_d = 2'b11;
      S_SHIFT: mode_d = shift_lsb ? 2'b10 : 2'b01;
      default: mode_d = 2'b00;
    endcase
  end

  // Control and pin registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      buf_full  <= 1'b0;
      sr_mode   <= 2'b00;
      sr_p_in   <= '0;
      sr_s_in   <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      sr_mode   <= mode_d;
      sr_s_in   <= (state_d == S_SHIFT) ? fill_bit : 1'b0;
      busy      <= (state_d != S_IDLE);
      word_done <= shift_last;
      if (accept)                  buf_full <= 1'b1;
      else if (state_q == S_LOAD)  buf_full <= 1'b0;
      if (state_d == S_LOAD)       sr_p_in  <= buf_data;
      // bit_cnt clears as LOAD ends so it still reads WIDTH during a
      // streaming LOAD that coincides with word_done.
      if (state_q == S_LOAD)       bit_cnt  <= '0;
      else if (state_q == S_SHIFT) bit_cnt  <= bit_cnt + CNT_W'(1);
      if (state_q == S_GAP)        gap_cnt  <= gap_cnt + 8'd1;
      else                         gap_cnt  <= '0;
    end
  end

  // Buffered word and per-word direction
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data <= in_data;
      buf_lsb  <= in_lsb;
    end
    if (state_q == S_LOAD) cur_lsb <= buf_lsb;
  end

endmodule

// File: tb/tb_shift_tx_seq.sv
// Directed bench for shift_tx_seq: two instances (GAP_CYCLES 0 and 2), each
// feeding a behavioural universal shift register whose s_out is observed.
module tb_shift_tx_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_lsb = 1'b0;
  logic       fill_bit = 1'b0;
  logic       in_valid0 = 1'b0;
  logic       in_valid2 = 1'b0;

  logic       ready0, s_in0, busy0, wd0;
  logic [1:0] mode0;
  logic [7:0] p_in0;
  logic [3:0] cnt0;
  logic       ready2, s_in2, busy2, wd2;
  logic [1:0] mode2;
  logic [7:0] p_in2;
  logic [3:0] cnt2;

  logic [7:0] q0, q2;
  logic       so0, so2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_tx_seq #(.WIDTH(8), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_lsb(in_lsb),
    .in_valid(in_valid0), .in_ready(ready0), .fill_bit(fill_bit),
    .sr_mode(mode0), .sr_p_in(p_in0), .sr_s_in(s_in0), .busy(busy0),
    .bit_cnt(cnt0), .word_done(wd0));

  shift_tx_seq #(.WIDTH(8), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_lsb(in_lsb),
    .in_valid(in_valid2), .in_ready(ready2), .fill_bit(fill_bit),
    .sr_mode(mode2), .sr_p_in(p_in2), .sr_s_in(s_in2), .busy(busy2),
    .bit_cnt(cnt2), .word_done(wd2));

  // Universal shift register models; s_out registers the bit shifted out.
  always_ff @(posedge clk) begin
    if (rst) begin
      q0 <= 8'h00; so0 <= 1'b0;
    end else begin
      case (mode0)
        2'b01: begin q0 <= {q0[6:0], s_in0}; so0 <= q0[7]; end
        2'b10: begin q0 <= {s_in0, q0[7:1]}; so0 <= q0[0]; end
        2'b11: q0 <= p_in0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q2 <= 8'h00; so2 <= 1'b0;
    end else begin
      case (mode2)
        2'b01: begin q2 <= {q2[6:0], s_in2}; so2 <= q2[7]; end
        2'b10: begin q2 <= {s_in2, q2[7:1]}; so2 <= q2[0]; end
        2'b11: q2 <= p_in2;
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid0 = 1'b0;
    in_valid2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated word on u0: accept, LOAD, 8 shifts, word_done, idle.
  task automatic run_word0(input logic [7:0] data, input logic lsb, input logic fill,
                           input logic [7:0] exp_seq);
    int         good;
    int         done_n;
    logic [7:0] seq;
    in_data = data; in_lsb = lsb; fill_bit = fill; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    check("ready_after_accept", 32'(ready0), 32'd0);
    done_n = int'(wd0);
    tick();
    check("load_mode", 32'(mode0), 32'd3);
    check("load_p_in", 32'(p_in0), 32'(data));
    done_n += int'(wd0);
    good = 0;
    seq = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      done_n += int'(wd0);
      if (mode0 == (lsb ? 2'b10 : 2'b01) && s_in0 == fill && cnt0 == 4'(k) && busy0)
        good++;
      if (k > 0) seq = {seq[6:0], so0};
    end
    tick();
    seq = {seq[6:0], so0};
    done_n += int'(wd0);
    check("shift_cycles", 32'(good), 32'd8);
    check("serial_out", 32'(seq), 32'(exp_seq));
    check("word_done_pulse", 32'(wd0), 32'd1);
    check("bit_cnt_final", 32'(cnt0), 32'd8);
    tick();
    done_n += int'(wd0);
    check("idle_after_word", 32'({busy0, mode0, s_in0}), 32'd0);
    tick();
    done_n += int'(wd0);
    check("word_done_count", 32'(done_n), 32'd1);
  endtask

  initial begin
    int         busy_n, first_b, last_b, wd_a, wd_b, wd_n, loads, acc_edge, low_seen;
    logic       go;
    logic [7:0] pin1, pin2;
    logic [1:0] m2 [0:31];
    logic [31:0] b2;

    // Reset state
    tick();
    tick();
    check("rst_outputs", 32'({mode0, s_in0, busy0, wd0}), 32'd0);
    check("rst_bit_cnt", 32'(cnt0), 32'd0);
    check("rst_p_in", 32'(p_in0), 32'd0);
    check("rst_ready_low", 32'(ready0), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(ready0), 32'd1);

    // MSB-first A5, then LSB-first 01 with fill 1
    run_word0(8'hA5, 1'b0, 1'b0, 8'hA5);
    run_word0(8'h01, 1'b1, 1'b1, 8'h80);
    check("reg_filled", 32'(q0), 32'hFF);

    // Back-to-back C3 then 3C on u0, in_valid held while the buffer is full
    in_data = 8'hC3; in_lsb = 1'b0; fill_bit = 1'b0; in_valid0 = 1'b1;
    tick();
    in_data = 8'h3C;
    busy_n = 0; first_b = -1; last_b = -1; wd_a = -1; wd_b = -1; wd_n = 0;
    loads = 0; acc_edge = -1; low_seen = 0; pin1 = 8'h00; pin2 = 8'h00;
    for (int c = 0; c < 30; c++) begin
      if (busy0) begin busy_n++; if (first_b < 0) first_b = c; last_b = c; end
      if (wd0) begin if (wd_a < 0) wd_a = c; else wd_b = c; wd_n++; end
      if (mode0 == 2'b11) begin if (loads == 0) pin1 = p_in0; else pin2 = p_in0; loads++; end
      if (in_valid0 && !ready0) low_seen = 1;
      go = in_valid0 && ready0;
      tick();
      if (go) begin acc_edge = c + 1; in_valid0 = 1'b0; end
    end
    in_valid0 = 1'b0;
    check("b2b_ready_dropped", 32'(low_seen), 32'd1);
    check("b2b_accept_edge", 32'(acc_edge), 32'd3);
    check("b2b_busy_cycles", 32'(busy_n), 32'd18);
    check("b2b_busy_span", 32'(last_b - first_b + 1), 32'd18);
    check("b2b_done_count", 32'(wd_n), 32'd2);
    check("b2b_done_spacing", 32'(wd_b - wd_a), 32'd9);
    check("b2b_load_count", 32'(loads), 32'd2);
    check("b2b_first_p_in", 32'(pin1), 32'hC3);
    check("b2b_second_p_in", 32'(pin2), 32'h3C);

    // GAP_CYCLES=2 instance with two queued words
    do_reset();
    in_data = 8'hC3; in_lsb = 1'b0; in_valid2 = 1'b1;
    tick();
    in_data = 8'h3C;
    b2 = 32'd0; wd_a = -1; wd_b = -1; busy_n = 0; pin2 = 8'h00;
    for (int c = 0; c < 32; c++) begin
      m2[c] = mode2;
      b2[c] = busy2;
      if (busy2) busy_n++;
      if (wd2) begin if (wd_a < 0) wd_a = c; else wd_b = c; end
      if (c == 12) pin2 = p_in2;
      go = in_valid2 && ready2;
      tick();
      if (go) in_valid2 = 1'b0;
    end
    in_valid2 = 1'b0;
    check("gap_mode_seq", 32'({m2[9], m2[10], m2[11], m2[12]}), 32'h43);
    check("gap_busy", 32'(b2[11:10]), 32'd3);
    check("gap_first_done", 32'(wd_a), 32'd10);
    check("gap_done_spacing", 32'(wd_b - wd_a), 32'd11);
    check("gap_busy_cycles", 32'(busy_n), 32'd22);
    check("gap_second_p_in", 32'(pin2), 32'h3C);

    // Reset after the 3rd shift of word 55
    do_reset();
    in_data = 8'h55; in_lsb = 1'b0; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_bit_cnt", 32'(cnt0), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_mode_busy", 32'({mode0, busy0, wd0, s_in0}), 32'd0);
    check("mid_rst_bit_cnt", 32'(cnt0), 32'd0);
    check("mid_rst_ready", 32'(ready0), 32'd1);
    wd_n = 0; busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      wd_n += int'(wd0);
      busy_n += int'(busy0);
    end
    check("mid_rst_no_done", 32'(wd_n), 32'd0);
    check("mid_rst_stays_idle", 32'(busy_n), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
